// File: rtl/subleq_mem_responder_if.sv
// Request/response bus between the SUBLEQ processor (master) and its memory
// responder (slave): valid/ready request channel plus a one-cycle response pulse.
interface subleq_mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/subleq_mem_responder.sv
// Memory-side responder for the SUBLEQ processor bus.
// Single-word reads/writes with WAIT_CYCLES wait states, one address (OUT_ADDR)
// mapped onto a one-word buffered output port, and a host preload port that
// writes the RAM while the responder is idle.
// Optional feature: define MEM_WRPROT_EN to reject bus writes below PROT_TOP
// (resp_err=1, RAM unchanged, old word returned). Preloads are never blocked.
module subleq_mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int OUT_ADDR    = 2**ADDR_W - 1,
    parameter int PROT_TOP    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    subleq_mem_responder_if.slave bus,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready,
    input  logic                  load_en,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [DATA_W-1:0]     load_data
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_STALL} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              accept;
    logic              cmt_write;
    logic [ADDR_W-1:0] cmt_addr;
    logic [DATA_W-1:0] cmt_wdata;
    logic              commit;
    logic              out_stall;
    logic              wr_blocked;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign bus.req_ready  = (state == S_IDLE) && !load_en;
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign accept         = bus.req_valid && bus.req_ready;

`ifdef MEM_WRPROT_EN
    assign wr_blocked = cmt_write && (cmt_addr != OUT_A) && (32'(cmt_addr) < PROT_TOP);
`else
    assign wr_blocked = 1'b0;
`endif

    // Next state and commit strobe; a zero-wait request commits straight from the bus fields
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        cmt_write  = (state == S_IDLE) ? bus.req_write : lat_write;
        cmt_addr   = (state == S_IDLE) ? bus.req_addr  : lat_addr;
        cmt_wdata  = (state == S_IDLE) ? bus.req_wdata : lat_wdata;
        out_stall  = cmt_write && (cmt_addr == OUT_A) && out_valid && !out_ready;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        if (out_stall) begin
                            next_state = S_STALL;
                        end else begin
                            next_state = S_RESP;
                            commit     = 1'b1;
                        end
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    if (out_stall) begin
                        next_state = S_STALL;
                    end else begin
                        next_state = S_RESP;
                        commit     = 1'b1;
                    end
                end
            end
            S_STALL: begin
                if (!out_stall) begin
                    next_state = S_RESP;
                    commit     = 1'b1;
                end
            end
            S_RESP: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Wait-state counter, loaded at acceptance and counted down in WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if ((state == S_WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Capture the request fields at acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end
    end

    // Response data/error and the output buffer, updated on the edge entering RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q   <= '0;
            err_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (commit) begin
                err_q <= wr_blocked;
                if (cmt_addr == OUT_A) begin
                    if (cmt_write) begin
                        out_data  <= cmt_wdata;
                        out_valid <= 1'b1;
                        rdata_q   <= cmt_wdata;
                    end else begin
                        rdata_q <= {{(DATA_W-1){1'b0}}, out_valid};
                    end
                end else if (cmt_write && !wr_blocked) begin
                    rdata_q <= cmt_wdata;
                end else begin
                    rdata_q <= mem[cmt_addr];
                end
            end
        end
    end

    // RAM write port: host preload in IDLE, otherwise a committed bus write; never cleared
    always_ff @(posedge clk) begin
        if (!reset) begin
            if ((state == S_IDLE) && load_en) begin
                mem[load_addr] <= load_data;
            end else if (commit && cmt_write && (cmt_addr != OUT_A) && !wr_blocked) begin
                mem[cmt_addr] <= cmt_wdata;
            end
        end
    end
endmodule

// File: tb/tb_subleq_mem_responder.sv
// Scoreboard bench for subleq_mem_responder: the driver pushes expected
// responses and output words computed from a plain array model of the memory,
// and independent monitors pop and compare whenever the DUT presents them.
module tb_subleq_mem_responder;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 8;
    localparam int WAIT     = 2;
    localparam int OUT_ADDR = 255;
    localparam int PROT_TOP = 16;
    localparam int DEPTH    = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    always #5 clk = ~clk;

    subleq_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    subleq_mem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT),
        .OUT_ADDR(OUT_ADDR), .PROT_TOP(PROT_TOP)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              check_rdata;
        logic              err;
        logic              exact;
        int                acc_cycle;
    } exp_t;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    exp_t              resp_q[$];
    logic [DATA_W-1:0] out_q[$];
    int                cycle      = 0;
    int                n_checks   = 0;
    int                n_fail     = 0;
    int                resp_count = 0;
    logic              hold_out   = 1'b0;

    always @(posedge clk) cycle++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic is_protected(input logic [ADDR_W-1:0] a);
`ifdef MEM_WRPROT_EN
        return (int'(a) != OUT_ADDR) && (int'(a) < PROT_TOP);
`else
        return 1'b0;
`endif
    endfunction

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        ref_mem[a] = d;
        load_en = 1'b0;
    endtask

    // Present one request, wait for acceptance and push its expected response
    task automatic issue_req(input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wd, input logic collide,
                             input logic commit_model);
        exp_t e;
        int   first_i;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wd;
        if (collide) begin
            load_en = 1'b1; load_addr = addr; load_data = DATA_W'($urandom);
            @(negedge clk);
            check_output("req_ready_during_load", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            ref_mem[addr] = load_data;
            load_en = 1'b0;
        end
        first_i = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                first_i = i;
                break;
            end
        end
        if (first_i < 0) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL accept_timeout: got no req_ready, expected acceptance");
        end else begin
            if (collide) check_output("accept_after_load", 32'(first_i), 32'd0);
            e.acc_cycle = cycle; e.exact = 1'b1; e.check_rdata = 1'b1; e.err = 1'b0; e.rdata = '0;
            if (int'(addr) == OUT_ADDR) begin
                if (wr) begin
                    out_q.push_back(wd);
                    e.check_rdata = 1'b0;
                    e.exact = 1'b0;
                end else begin
                    e.rdata = {15'b0, out_q.size() > 0};
                end
            end else if (wr) begin
                if (is_protected(addr)) begin
                    e.err = 1'b1;
                    e.rdata = ref_mem[addr];
                end else begin
                    e.rdata = wd;
                    if (commit_model) ref_mem[addr] = wd;
                end
            end else begin
                e.rdata = ref_mem[addr];
            end
            resp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (resp_q.size() == 0) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok == 0) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL resp_timeout: got no resp_valid, expected %0d pending", resp_q.size());
            resp_q.delete();
        end
    endtask

    task automatic apply_stimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                                  input logic [DATA_W-1:0] wd, input logic collide);
        issue_req(wr, addr, wd, collide, 1'b1);
        wait_resp();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
        check_output({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check_output({tag, "_resp_rdata"}, 32'(bus.resp_rdata), 32'd0);
        check_output({tag, "_resp_err"},   32'(bus.resp_err),   32'd0);
        check_output({tag, "_out_valid"},  32'(out_valid),      32'd0);
        check_output({tag, "_out_data"},   32'(out_data),       32'd0);
    endtask

    // Consumer on the output port: random acceptance unless the driver holds it off
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = hold_out ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Response monitor: every resp_valid pops one expected response
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!reset && bus.resp_valid) begin
                resp_count++;
                if (resp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL unexpected_resp: got resp_valid, expected none");
                end else begin
                    e = resp_q.pop_front();
                    if (e.check_rdata) check_output("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
                    check_output("resp_err", 32'(bus.resp_err), 32'(e.err));
                    lat = cycle - e.acc_cycle;
                    if (e.exact) begin
                        check_output("latency", 32'(lat), 32'(WAIT + 1));
                    end else begin
                        n_checks++;
                        if (lat < WAIT + 1) begin
                            n_fail++;
                            $display("[TB] FAIL min_latency: got %0d, expected >= %0d", lat, WAIT + 1);
                        end
                    end
                end
            end
        end
    end

    // Output port monitor: every taken word pops one expected word
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL unexpected_out: got word 0x%0h, expected none", out_data);
                end else begin
                    check_output("out_data", 32'(out_data), 32'(out_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rc;
        int r;
        logic [ADDR_W-1:0] a;
        logic              w;
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Fill the whole RAM so every later read has a known value
        for (int i = 0; i < DEPTH; i++) preload(ADDR_W'(i), DATA_W'($urandom));

        // Preloaded read, write-then-read
        preload(8'd5, 16'h1234);
        apply_stimulus(1'b0, 8'd5, 16'h0, 1'b0);
        apply_stimulus(1'b1, 8'd7, 16'hFFFE, 1'b0);
        apply_stimulus(1'b0, 8'd7, 16'h0, 1'b0);

        // Full output buffer stalls the second OUT_ADDR write
        hold_out = 1'b1; out_ready = 1'b0;
        apply_stimulus(1'b1, 8'(OUT_ADDR), 16'h0041, 1'b0);
        issue_req(1'b1, 8'(OUT_ADDR), 16'h0042, 1'b0, 1'b1);
        rc = resp_count;
        repeat (8) @(posedge clk);
        #1;
        check_output("stall_no_resp", 32'(resp_count), 32'(rc));
        check_output("stall_out_valid", 32'(out_valid), 32'd1);
        check_output("stall_out_data", 32'(out_data), 32'h0041);
        hold_out = 1'b0; out_ready = 1'b1;
        wait_resp();
        for (int i = 0; i < 100 && out_q.size() != 0; i++) @(posedge clk);
        #1;
        check_output("stall_out_drained", 32'(out_q.size()), 32'd0);

        // Preload colliding with a request
        apply_stimulus(1'b0, 8'd40, 16'h0, 1'b1);

        // Reset during WAIT abandons a write
        preload(8'd9, 16'h0003);
        issue_req(1'b1, 8'd9, 16'hBEEF, 1'b0, 1'b0);
        void'(resp_q.pop_back());
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        out_q.delete();
        rc = resp_count;
        repeat (4) @(posedge clk);
        #1;
        check_output("midreset_no_resp", 32'(resp_count), 32'(rc));
        apply_stimulus(1'b0, 8'd9, 16'h0, 1'b0);

        // Protected region (err only when MEM_WRPROT_EN) and an unprotected address
        preload(8'd3, 16'h0001);
        apply_stimulus(1'b1, 8'd3, 16'h7777, 1'b0);
        apply_stimulus(1'b0, 8'd3, 16'h0, 1'b0);
        apply_stimulus(1'b1, 8'd20, 16'h5A5A, 1'b0);
        apply_stimulus(1'b0, 8'd20, 16'h0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      a = 8'(OUT_ADDR);
            else if (r < 5) a = 8'($urandom_range(0, 31));
            else            a = 8'($urandom);
            w = 1'($urandom_range(0, 1));
            if ((int'(a) == OUT_ADDR) && !w) begin
                hold_out = 1'b1; out_ready = 1'b0;
                apply_stimulus(w, a, 16'h0, 1'b0);
                hold_out = 1'b0;
            end else begin
                apply_stimulus(w, a, DATA_W'($urandom), ($urandom_range(0, 4) == 0));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        for (int i = 0; i < 200 && out_q.size() != 0; i++) @(posedge clk);
        #1;
        check_output("final_out_drained", 32'(out_q.size()), 32'd0);
        check_output("final_resp_empty", 32'(resp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/subleq_mem_responder.md
Name: subleq_mem_responder

Overview:
- Memory-side responder for the SUBLEQ processor's external bus. It services single-word read/write requests from the processor (the initiator) over a valid/ready request and one-cycle response handshake.
- Insertable wait states model slow memory.
- One address is memory-mapped to a buffered output port.
- Includes a host preload port for loading programs before or between runs.

Parameters:
- DATA_W, 16, data word width (two's complement).
- ADDR_W, 8, address width; memory depth is 2**ADDR_W words.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response (0 allowed).
- OUT_ADDR, 2**ADDR_W-1, address mapped to the output port instead of the RAM.
- PROT_TOP, 16, used only with MEM_WRPROT_EN: addresses below PROT_TOP are write-protected.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  processor presents a request.
- req_ready  out  1  responder accepts the request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  DATA_W  read data; valid with resp_valid.
- resp_err  out  1  write rejected; valid with resp_valid.
- out_valid  out  1  output buffer holds a word.
- out_data  out  DATA_W  buffered output word.
- out_ready  in  1  consumer takes out_data when out_valid=1.
- load_en  in  1  host preload write strobe.
- load_addr  in  ADDR_W  preload address.
- load_data  in  DATA_W  preload data.

Behaviour:
- Reset (synchronous, active-high) sets:
  - state to IDLE; req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - out_valid=0, out_data=0.
  - Wait counter to 0.
  - RAM contents are NOT cleared.
- States: IDLE, WAIT, RESP, STALL.
- req_ready = (state==IDLE) && !load_en. A request is accepted on a cycle with req_valid && req_ready. The addr, write, and wdata fields are latched at acceptance.
- IDLE:
  - On acceptance, go to WAIT with counter = WAIT_CYCLES-1.
  - If WAIT_CYCLES==0, go directly to RESP.
  - If load_en=1, write RAM[load_addr] = load_data. load_en has priority over req_valid: the request is not accepted that cycle.
  - load_en outside IDLE is ignored.
- WAIT: decrement the counter each cycle. At 0, go to RESP, or to STALL if the latched request is a write to OUT_ADDR while out_valid=1 and out_ready=0.
- STALL: hold until out_valid=0 or out_ready=1, then go to RESP.
- Entering RESP (same edge), the latched request takes effect:
  - Read of a RAM address: resp_rdata = RAM[addr].
  - Read of OUT_ADDR: resp_rdata = {0..., out_valid}.
  - Write of a RAM address: RAM[addr] = wdata; resp_rdata = wdata.
  - Write of OUT_ADDR: out_data = wdata, out_valid = 1; RAM is not written.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Latency: resp_valid is high WAIT_CYCLES+1 cycles after the acceptance edge, plus any STALL cycles. Back-to-back requests have a minimum spacing of WAIT_CYCLES+2 cycles.
- Output buffer:
  - out_valid clears on an out_valid && out_ready cycle, unless a new OUT_ADDR write is committed on the same edge; in that case the buffer reloads and out_valid stays 1.
  - A full buffer never drops data.
- Outside RESP, resp_rdata and resp_err hold their last values.
- Reset mid-operation: a request in WAIT or STALL is abandoned with no RAM or output side effect and no resp_valid.
- Address arithmetic is unsigned; no wrap-around beyond the depth because ADDR_W covers the full range.

Optional Feature:
- MEM_WRPROT_EN defined:
  - A write with addr < PROT_TOP (not OUT_ADDR) completes normally in timing but leaves RAM unchanged.
  - resp_err=1 with resp_valid; resp_rdata = old RAM[addr].
  - Preload writes bypass protection.
- MEM_WRPROT_EN undefined: all writes commit; resp_err is constant 0.

Test Plan:
- Preload RAM[5]=0x1234 via load_en; read addr 5 with WAIT_CYCLES=2 -> resp_valid on cycle 3 after acceptance, resp_rdata=0x1234, resp_err=0.
- Write addr 7 = 0xFFFE, then read addr 7 -> 0xFFFE. With WAIT_CYCLES=0, resp_valid is on the cycle after acceptance.
- Write 0x0041 to OUT_ADDR with out_ready=0, then a second OUT_ADDR write of 0x0042 -> second request stays in STALL (no resp_valid) until out_ready=1. out_data sequence is 0x0041 then 0x0042; RAM[OUT_ADDR] is unchanged.
- Assert load_en together with req_valid in IDLE -> req_ready=0, preload written, request accepted on the next cycle.
- Assert reset during WAIT of a write to addr 9 (old 0x0003) -> no resp_valid, RAM[9] still 0x0003, all outputs at reset values on the next cycle.
- With MEM_WRPROT_EN and PROT_TOP=16: write 0x7777 to addr 3 (old 0x0001) -> resp_err=1, resp_rdata=0x0001, RAM[3] unchanged. Write to addr 20 -> resp_err=0 and the write commits.
